// File: rtl/alu_accumulator_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_accumulator_seq
// Brief    : Handshaked 8-bit accumulator ALU with iterative 4x4 shift-add MUL.
// Revision : 1.0 - initial release
// ============================================================================
module alu_accumulator_seq #(
    parameter int MUL_STEPS = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       op_valid,
    output logic       op_ready,
    input  logic [2:0] func,
    input  logic [3:0] a,
    input  logic       clr,
    output logic       res_valid,
    output logic       busy,
    output logic [7:0] reg_q
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_MUL  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [2:0] F_ADD   = 3'd0;
    localparam logic [2:0] F_ORXOR = 3'd1;
    localparam logic [2:0] F_ANY   = 3'd2;
    localparam logic [2:0] F_CAT   = 3'd3;
    localparam logic [2:0] F_SHL   = 3'd4;
    localparam logic [2:0] F_SHR   = 3'd5;
    localparam logic [2:0] F_MUL   = 3'd6;
    localparam logic [2:0] F_HOLD  = 3'd7;

    localparam logic [1:0] LAST_STEP = 2'(MUL_STEPS - 1);

    logic [1:0] state_q, state_d;
    logic [3:0] a_q, a_d;
    logic [3:0] b_q, b_d;
    logic [2:0] func_q, func_d;
    logic       clr_q, clr_d;
    logic [1:0] cnt_q, cnt_d;
    logic [7:0] acc_q, acc_d;
    logic [7:0] reg_d;
    logic [7:0] exec_res;
    logic [7:0] acc_step;

    // reg_q cannot change while an op is in flight, so it serves directly as R.
    always_comb begin
        exec_res = reg_q;
        if (clr_q) begin
            exec_res = 8'h00;
        end else begin
            case (func_q)
                F_ADD:   exec_res = {4'b0, a_q} + {4'b0, b_q};
                F_ORXOR: exec_res = {a_q | b_q, a_q ^ b_q};
                F_ANY:   exec_res = {7'b0, (|a_q) | (|b_q)};
                F_CAT:   exec_res = {a_q, b_q};
                F_SHL:   exec_res = a_q[3] ? 8'h00 : (reg_q << a_q[2:0]);
                F_SHR:   exec_res = a_q[3] ? 8'h00 : (reg_q >> a_q[2:0]);
                F_MUL:   exec_res = reg_q;
                F_HOLD:  exec_res = reg_q;
                default: exec_res = reg_q;
            endcase
        end
    end

    assign acc_step = b_q[cnt_q] ? (acc_q + ({4'b0, a_q} << cnt_q)) : acc_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        func_d  = func_q;
        clr_d   = clr_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        reg_d   = reg_q;
        case (state_q)
            S_IDLE: begin
                if (op_valid) begin
                    a_d    = a;
                    b_d    = reg_q[3:0];
                    func_d = func;
                    clr_d  = clr;
                    cnt_d  = 2'd0;
                    acc_d  = 8'h00;
                    state_d = (!clr && func == F_MUL) ? S_MUL : S_EXEC;
                end
            end
            S_EXEC: begin
                reg_d   = exec_res;
                state_d = S_DONE;
            end
            S_MUL: begin
                acc_d = acc_step;
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == LAST_STEP) begin
                    reg_d   = acc_step;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            a_q     <= 4'h0;
            b_q     <= 4'h0;
            func_q  <= 3'h0;
            clr_q   <= 1'b0;
            cnt_q   <= 2'd0;
            acc_q   <= 8'h00;
            reg_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            func_q  <= func_d;
            clr_q   <= clr_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            reg_q   <= reg_d;
        end
    end

    assign op_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign res_valid = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_alu_accumulator_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_accumulator_seq
// Brief    : Directed plus random checks of alu_accumulator_seq against a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_accumulator_seq;

    logic       clk;
    logic       resetn;
    logic       op_valid;
    logic       op_ready;
    logic [2:0] func;
    logic [3:0] a;
    logic       clr;
    logic       res_valid;
    logic       busy;
    logic [7:0] reg_q;

    int         checks;
    int         errors;
    logic [7:0] model_reg;

    alu_accumulator_seq #(.MUL_STEPS(4)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .func      (func),
        .a         (a),
        .clr       (clr),
        .res_valid (res_valid),
        .busy      (busy),
        .reg_q     (reg_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference result straight from the function table, using plain arithmetic.
    function automatic logic [7:0] ref_result(input logic c, input logic [2:0] f,
                                              input logic [3:0] av, input logic [7:0] r);
        logic [7:0] ax;
        logic [7:0] bx;
        ax = {4'b0, av};
        bx = {4'b0, r[3:0]};
        if (c) return 8'h00;
        case (f)
            3'd0: return ax + bx;
            3'd1: return (((ax | bx) * 8'd16) + (ax ^ bx));
            3'd2: return (ax != 8'd0 || bx != 8'd0) ? 8'd1 : 8'd0;
            3'd3: return ax * 8'd16 + bx;
            3'd4: return (av >= 4'd8) ? 8'h00 : 8'((16'(r) * (16'd1 << av)) % 16'd256);
            3'd5: return (av >= 4'd8) ? 8'h00 : 8'(r / (8'd1 << av));
            3'd6: return ax * bx;
            default: return r;
        endcase
    endfunction

    task automatic run_op(input logic c, input logic [2:0] f, input logic [3:0] av,
                          input bit hold);
        logic [7:0] exp_res;
        int         exp_lat;
        int         n;
        @(negedge clk);
        check("ready_before_req", op_ready, 1'b1);
        clr      = c;
        func     = f;
        a        = av;
        op_valid = 1'b1;
        exp_res  = ref_result(c, f, av, model_reg);
        exp_lat  = (!c && f == 3'd6) ? 4 : 1;
        @(posedge clk);
        #1;
        if (!hold) begin
            op_valid = 1'b0;
            a    = 4'($urandom);
            func = 3'($urandom);
            clr  = 1'($urandom);
        end
        n = 0;
        while (n < 10) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (res_valid) break;
            check("busy_in_flight", busy, 1'b1);
        end
        check("latency", n, exp_lat);
        check("result", reg_q, exp_res);
        model_reg = exp_res;
        @(negedge clk);
        check("pulse_end", res_valid, 1'b0);
        check("idle_busy", busy, 1'b0);
        check("idle_ready", op_ready, 1'b1);
        check("idle_hold_reg", reg_q, model_reg);
        op_valid = 1'b0;
    endtask

    initial begin
        bit seen_pulse;
        checks    = 0;
        errors    = 0;
        model_reg = 8'h00;
        resetn    = 1'b0;
        op_valid  = 1'b0;
        func      = 3'd0;
        a         = 4'd0;
        clr       = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", op_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_reg", reg_q, 8'h00);
        check("rst_valid", res_valid, 1'b0);
        resetn = 1'b1;
        @(negedge clk);
        check("idle_reg", reg_q, 8'h00);

        run_op(1'b0, 3'd3, 4'hA, 1'b0);
        check("cat_A0", reg_q, 8'hA0);
        run_op(1'b0, 3'd0, 4'hF, 1'b0);
        check("add_0F", reg_q, 8'h0F);
        run_op(1'b0, 3'd0, 4'h1, 1'b0);
        check("add_10", reg_q, 8'h10);

        run_op(1'b1, 3'd0, 4'h0, 1'b0);
        run_op(1'b0, 3'd0, 4'hF, 1'b0);
        run_op(1'b0, 3'd6, 4'hF, 1'b1);
        check("mul_E1", reg_q, 8'hE1);

        run_op(1'b1, 3'd2, 4'h3, 1'b0);
        run_op(1'b0, 3'd0, 4'h1, 1'b0);
        run_op(1'b0, 3'd3, 4'h8, 1'b0);
        check("cat_81", reg_q, 8'h81);
        run_op(1'b0, 3'd4, 4'h1, 1'b0);
        check("shl_02", reg_q, 8'h02);
        run_op(1'b0, 3'd5, 4'h1, 1'b0);
        check("shr_01", reg_q, 8'h01);
        run_op(1'b0, 3'd4, 4'h8, 1'b0);
        check("shl8_00", reg_q, 8'h00);

        run_op(1'b0, 3'd0, 4'h5, 1'b0);
        run_op(1'b0, 3'd1, 4'h3, 1'b0);
        check("orxor_76", reg_q, 8'h76);
        run_op(1'b0, 3'd2, 4'h0, 1'b0);
        check("any_01", reg_q, 8'h01);
        run_op(1'b1, 3'd7, 4'h0, 1'b0);
        check("clr_00", reg_q, 8'h00);

        // Abort a multiply in its second cycle with an asynchronous reset.
        run_op(1'b0, 3'd0, 4'h7, 1'b0);
        @(negedge clk);
        clr = 1'b0; func = 3'd6; a = 4'h9; op_valid = 1'b1;
        @(posedge clk);
        #1 op_valid = 1'b0;
        @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        check("abort_ready", op_ready, 1'b1);
        check("abort_busy", busy, 1'b0);
        check("abort_reg", reg_q, 8'h00);
        check("abort_valid", res_valid, 1'b0);
        @(negedge clk);
        resetn = 1'b1;
        model_reg = 8'h00;
        seen_pulse = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (res_valid) seen_pulse = 1'b1;
        end
        check("abort_no_pulse", seen_pulse, 1'b0);
        run_op(1'b0, 3'd3, 4'h5, 1'b0);
        check("post_abort_cat", reg_q, 8'h50);

        for (int i = 0; i < 40; i++) begin
            run_op(($urandom_range(7) == 0), 3'($urandom), 4'($urandom), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
